// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read and write control stages.
package fifo_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  typedef logic [PTR_W-1:0] level_t;

  localparam level_t LEVEL_FULL = level_t'(DEPTH);

endpackage

// File: rtl/fifo_level_counter.sv
// Occupancy tracker: counts committed writes against accepted reads and
// reports level, empty/full and the overrun condition for this cycle.
module fifo_level_counter
  import fifo_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_wrValid,
  input  logic   i_rdAccept,
  output level_t o_level,
  output logic   o_empty,
  output logic   o_full,
  output logic   o_wrAccept,
  output logic   o_overrun
);

  level_t r_level;
  logic   r_empty;
  logic   r_full;
  level_t w_levelNext;
  logic   w_atFull;

  assign w_atFull = (r_level == LEVEL_FULL);

  // A read at full frees a slot in the same cycle, so the write still lands.
  assign o_wrAccept = i_wrValid & (~w_atFull | i_rdAccept);
  assign o_overrun  = i_wrValid & w_atFull & ~i_rdAccept;

  // Next occupancy from the accepted write/read pair.
  always_comb begin
    w_levelNext = r_level;
    if (o_wrAccept && !i_rdAccept) begin
      w_levelNext = r_level + level_t'(1);
    end else if (!o_wrAccept && i_rdAccept) begin
      w_levelNext = r_level - level_t'(1);
    end
  end

  // Register level together with flags derived from the same next value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_level <= w_levelNext;
      r_empty <= (w_levelNext == '0);
      r_full  <= (w_levelNext == LEVEL_FULL);
    end
  end

  assign o_level = r_level;
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/fifo_output_control.sv
// Read-side FIFO controller: issues registered read strobes and addresses,
// tracks occupancy, and flags underflow, overrun and write-pointer slips.
module fifo_output_control
  import fifo_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   read_en,
  input  logic   wr_valid,
  input  level_t wr_ptr,
  input  logic   clear_err,
  output logic   read_en_o,
  output level_t ptr,
  output logic   empty,
  output logic   full,
  output level_t level,
  output logic   underflow,
  output logic   err_sticky,
  output logic   ptr_err
);

  logic   r_readEnO;
  level_t r_ptr;
  level_t r_rdCnt;
  level_t r_wrCnt;
  logic   r_underflow;
  logic   r_errSticky;
  logic   r_ptrErr;

  logic   w_rdAccept;
  logic   w_wrAccept;
  logic   w_overrun;
  logic   w_underflowNow;
  logic   w_ptrSlip;

  // Decisions use the registered empty flag, so a same-cycle write
  // never makes an empty FIFO readable.
  assign w_rdAccept     = read_en & ~empty;
  assign w_underflowNow = read_en & empty;
  assign w_ptrSlip      = w_wrAccept & (wr_ptr != r_wrCnt);

  fifo_level_counter u_levelCounter (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_wrValid  (wr_valid),
    .i_rdAccept (w_rdAccept),
    .o_level    (level),
    .o_empty    (empty),
    .o_full     (full),
    .o_wrAccept (w_wrAccept),
    .o_overrun  (w_overrun)
  );

  // Read strobe and address to storage; address holds when no read issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readEnO <= 1'b0;
      r_ptr     <= '0;
      r_rdCnt   <= '0;
    end else begin
      r_readEnO <= w_rdAccept;
      if (w_rdAccept) begin
        r_ptr   <= r_rdCnt;
        r_rdCnt <= r_rdCnt + level_t'(1);
      end
    end
  end

  // Expected write address advances only on writes that actually land.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrCnt <= '0;
    end else if (w_wrAccept) begin
      r_wrCnt <= r_wrCnt + level_t'(1);
    end
  end

  // Error reporting: underflow follows read_en each cycle, sticky flags
  // clear on request but a new event in the same cycle keeps them set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underflow <= 1'b0;
      r_errSticky <= 1'b0;
      r_ptrErr    <= 1'b0;
    end else begin
      r_underflow <= w_underflowNow;
      if (w_underflowNow || w_overrun) begin
        r_errSticky <= 1'b1;
      end else if (clear_err) begin
        r_errSticky <= 1'b0;
      end
      if (w_ptrSlip) begin
        r_ptrErr <= 1'b1;
      end else if (clear_err) begin
        r_ptrErr <= 1'b0;
      end
    end
  end

  assign read_en_o  = r_readEnO;
  assign ptr        = r_ptr;
  assign underflow  = r_underflow;
  assign err_sticky = r_errSticky;
  assign ptr_err    = r_ptrErr;

endmodule

// File: tb/tb_fifo_output_control.sv
// Randomised scoreboard bench for the FIFO read-side controller, using a
// queue-of-addresses reference model.
module tb_fifo_output_control;

  localparam int DEPTH = 16;
  localparam int WRAP  = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_en;
  logic       wr_valid;
  logic [4:0] wr_ptr;
  logic       clear_err;
  logic       read_en_o;
  logic [4:0] ptr;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       underflow;
  logic       err_sticky;
  logic       ptr_err;

  typedef struct {
    logic       readEnO;
    logic [4:0] ptr;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       underflow;
    logic       errSticky;
    logic       ptrErr;
  } expT;

  expT expQ[$];
  int  vectorsApplied = 0;
  int  miscompares    = 0;

  // Reference model state: addresses of entries currently stored.
  int         modelQ[$];
  int         modelWrCount;
  logic [4:0] modelPtr;
  logic       modelErr;
  logic       modelPtrErr;

  fifo_output_control dut (
    .clk        (clk),
    .reset      (reset),
    .read_en    (read_en),
    .wr_valid   (wr_valid),
    .wr_ptr     (wr_ptr),
    .clear_err  (clear_err),
    .read_en_o  (read_en_o),
    .ptr        (ptr),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .underflow  (underflow),
    .err_sticky (err_sticky),
    .ptr_err    (ptr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectorsApplied++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for the next edge.
  task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                               input logic [4:0] wptr, input logic clr);
    expT e;
    logic rdAcc, wrAcc, under, over;
    @(negedge clk);
    reset     = rst;
    read_en   = rd;
    wr_valid  = wr;
    wr_ptr    = wptr;
    clear_err = clr;
    if (rst) begin
      modelQ.delete();
      modelWrCount = 0;
      modelPtr     = '0;
      modelErr     = 1'b0;
      modelPtrErr  = 1'b0;
      e.readEnO    = 1'b0;
      e.underflow  = 1'b0;
    end else begin
      rdAcc = rd && (modelQ.size() > 0);
      wrAcc = wr && ((modelQ.size() < DEPTH) || rdAcc);
      under = rd && (modelQ.size() == 0);
      over  = wr && !wrAcc;
      if (rdAcc) modelPtr = 5'(modelQ.pop_front());
      if (wrAcc) begin
        if (int'(wptr) != modelWrCount) modelPtrErr = 1'b1;
        else if (clr) modelPtrErr = 1'b0;
        modelQ.push_back(modelWrCount);
        modelWrCount = (modelWrCount + 1) % WRAP;
      end else if (clr) begin
        modelPtrErr = 1'b0;
      end
      if (under || over) modelErr = 1'b1;
      else if (clr) modelErr = 1'b0;
      e.readEnO   = rdAcc;
      e.underflow = under;
    end
    e.ptr       = modelPtr;
    e.level     = 5'(modelQ.size());
    e.empty     = (modelQ.size() == 0);
    e.full      = (modelQ.size() == DEPTH);
    e.errSticky = modelErr;
    e.ptrErr    = modelPtrErr;
    expQ.push_back(e);
  endtask

  task automatic writeGood(input logic rd);
    applyStimulus(1'b0, rd, 1'b1, 5'(modelWrCount), 1'b0);
  endtask

  task automatic idle(input logic clr);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, clr);
  endtask

  // Monitor: compare every registered output just after each active edge.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("read_en_o",  int'(read_en_o),  int'(e.readEnO));
        if (e.readEnO) checkOutput("read_ptr", int'(ptr), int'(e.ptr));
        else           checkOutput("held_ptr", int'(ptr), int'(e.ptr));
        checkOutput("empty",      int'(empty),      int'(e.empty));
        checkOutput("full",       int'(full),       int'(e.full));
        checkOutput("level",      int'(level),      int'(e.level));
        checkOutput("underflow",  int'(underflow),  int'(e.underflow));
        checkOutput("err_sticky", int'(err_sticky), int'(e.errSticky));
        checkOutput("ptr_err",    int'(ptr_err),    int'(e.ptrErr));
      end
    end
  end

  initial begin
    int pWr, pRd, waited;
    reset = 1'b1; read_en = 1'b0; wr_valid = 1'b0; wr_ptr = '0; clear_err = 1'b0;
    modelWrCount = 0; modelPtr = '0; modelErr = 1'b0; modelPtrErr = 1'b0;

    // Reset, three writes, three reads.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) writeGood(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);

    // Underflow for two cycles, then clear.
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill, overrun, simultaneous read/write at full, then drain.
    for (int i = 0; i < DEPTH; i++) writeGood(1'b0);
    writeGood(1'b0);
    idle(1'b1);
    writeGood(1'b1);
    writeGood(1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);

    // Interleaved pairs across the pointer wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      writeGood(1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    end

    // Pointer slip held until cleared.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    writeGood(1'b0);
    writeGood(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Reset with occupancy, then read on the emptied FIFO.
    for (int i = 0; i < 4; i++) writeGood(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);

    // Random phases with varying write/read bias.
    for (int ph = 0; ph < 4; ph++) begin
      pWr = (ph == 0) ? 80 : (ph == 1) ? 30 : 55;
      pRd = (ph == 0) ? 30 : (ph == 1) ? 80 : 55;
      for (int i = 0; i < 150; i++) begin
        logic rst, rd, wr, clr;
        logic [4:0] wp;
        rst = ($urandom_range(0, 199) == 0);
        rd  = ($urandom_range(0, 99) < pRd);
        wr  = ($urandom_range(0, 99) < pWr);
        clr = ($urandom_range(0, 29) == 0);
        wp  = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 31)) : 5'(modelWrCount);
        applyStimulus(rst, rd, wr, wp, clr);
      end
    end
    idle(1'b0);

    waited = 0;
    while (expQ.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
